// File: rtl/pop_counter_bank.sv
// Bank of per-channel FIFO pop counters read one channel at a time over a req/valid handshake.
// Optional POP_TOTAL_EN adds total_out, a wrapping count of all pops on all channels.
module pop_counter_bank #(
  parameter int unsigned NUM_CH   = 5,
  parameter int unsigned CNT_W    = 5,
  parameter int unsigned IDX_W    = 3,
  parameter int unsigned SATURATE = 0
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic [NUM_CH-1:0] pop,
  input  logic              idle,
  input  logic              req,
  input  logic [IDX_W-1:0]  idx,
  input  logic              clr_on_rd,
  output logic              valid,
  output logic [CNT_W-1:0]  data_out,
  output logic              ovf,
  output logic              err,
`ifdef POP_TOTAL_EN
  output logic [CNT_W+IDX_W-1:0] total_out,
`endif
  output logic              busy
);

  localparam int unsigned TOT_W = CNT_W + IDX_W;

  typedef enum logic [1:0] {S_WAIT, S_DATA, S_HOLD} state_t;

  state_t             state_q, state_d;
  logic               accept;
  logic               idx_bad;
  logic [CNT_W-1:0]   sel_cnt;
  logic               sel_flag;
  logic [CNT_W-1:0]   cnt_q [NUM_CH];
  logic [CNT_W-1:0]   cnt_d [NUM_CH];
  logic [NUM_CH-1:0]  flag_q, flag_d;

  // Read-side FSM: next state and acceptance
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      S_WAIT: begin
        if (req && idle) begin
          accept  = 1'b1;
          state_d = S_DATA;
        end
      end
      S_DATA:  state_d = req ? S_HOLD : S_WAIT;
      S_HOLD:  if (!req) state_d = S_WAIT;
      default: state_d = S_WAIT;
    endcase
  end

  // Index check and pre-pop snapshot of the addressed channel
  always_comb begin
    idx_bad  = (32'(idx) >= NUM_CH);
    sel_cnt  = '0;
    sel_flag = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (idx == IDX_W'(i)) begin
        sel_cnt  = cnt_q[i];
        sel_flag = flag_q[i];
      end
    end
  end

  // Per-channel counter update; clear-on-read keeps a same-cycle pop
  always_comb begin
    flag_d = flag_q;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (pop[i]) begin
        if (&cnt_q[i]) begin
          flag_d[i] = 1'b1;
          if (SATURATE == 0) cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
      if (accept && clr_on_rd && !idx_bad && (idx == IDX_W'(i))) begin
        cnt_d[i]  = CNT_W'(pop[i]);
        flag_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int unsigned i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
      flag_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

  // Registered read outputs: capture at acceptance, hold, zero on return to S_WAIT
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q  <= S_WAIT;
      valid    <= 1'b0;
      busy     <= 1'b0;
      data_out <= '0;
      ovf      <= 1'b0;
      err      <= 1'b0;
    end else begin
      state_q <= state_d;
      valid   <= (state_d != S_WAIT);
      busy    <= (state_d != S_WAIT);
      if (accept) begin
        err      <= idx_bad;
        data_out <= idx_bad ? '0 : sel_cnt;
        ovf      <= idx_bad ? 1'b0 : sel_flag;
      end else if (state_d == S_WAIT) begin
        err      <= 1'b0;
        data_out <= '0;
        ovf      <= 1'b0;
      end
    end
  end

`ifdef POP_TOTAL_EN
  logic [TOT_W-1:0] tot_inc;

  always_comb begin
    tot_inc = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) tot_inc = tot_inc + TOT_W'(pop[i]);
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) total_out <= '0;
    else          total_out <= total_out + tot_inc;
  end
`endif

endmodule

// File: tb/tb_pop_counter_bank.sv
// Directed bench for pop_counter_bank: wrap and saturate instances driven in parallel.
module tb_pop_counter_bank;

  localparam int unsigned NUM_CH = 5;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned IDX_W  = 3;

  logic              clk;
  logic              reset_L;
  logic [NUM_CH-1:0] pop;
  logic              idle;
  logic              req;
  logic [IDX_W-1:0]  idx;
  logic              clr_on_rd;
  logic              valid, ovf, err, busy;
  logic [CNT_W-1:0]  data_out;
  logic              valid_s, ovf_s, err_s, busy_s;
  logic [CNT_W-1:0]  data_s;
`ifdef POP_TOTAL_EN
  logic [CNT_W+IDX_W-1:0] total_out, total_s;
`endif

  int checks = 0;
  int errors = 0;

  pop_counter_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .IDX_W(IDX_W), .SATURATE(0)) dut (
    .clk(clk), .reset_L(reset_L), .pop(pop), .idle(idle), .req(req), .idx(idx),
    .clr_on_rd(clr_on_rd), .valid(valid), .data_out(data_out), .ovf(ovf), .err(err),
`ifdef POP_TOTAL_EN
    .total_out(total_out),
`endif
    .busy(busy)
  );

  pop_counter_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .IDX_W(IDX_W), .SATURATE(1)) dut_s (
    .clk(clk), .reset_L(reset_L), .pop(pop), .idle(idle), .req(req), .idx(idx),
    .clr_on_rd(clr_on_rd), .valid(valid_s), .data_out(data_s), .ovf(ovf_s), .err(err_s),
`ifdef POP_TOTAL_EN
    .total_out(total_s),
`endif
    .busy(busy_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [IDX_W-1:0]  idx;
    logic              clr;
    logic [NUM_CH-1:0] p;
    logic [CNT_W-1:0]  d;
    logic              o;
    logic              e;
    logic [CNT_W-1:0]  ds;
    logic              os;
  } vec_t;

  vec_t vt [13];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full read: accept, check first valid cycle, hold cycle, release
  task automatic do_read(input string nm, input vec_t v);
    idle = 1'b1; req = 1'b1; idx = v.idx; clr_on_rd = v.clr; pop = v.p;
    check({nm, " pre-valid"}, 32'(valid), 32'd0);
    tick();
    pop = '0; clr_on_rd = 1'b0;
    check({nm, " valid"}, 32'(valid), 32'd1);
    check({nm, " busy"}, 32'(busy), 32'd1);
    check({nm, " data"}, 32'(data_out), 32'(v.d));
    check({nm, " ovf"}, 32'(ovf), 32'(v.o));
    check({nm, " err"}, 32'(err), 32'(v.e));
    check({nm, " sat data"}, 32'(data_s), 32'(v.ds));
    check({nm, " sat ovf"}, 32'(ovf_s), 32'(v.os));
    tick();
    check({nm, " hold valid"}, 32'(valid), 32'd1);
    check({nm, " hold data"}, 32'(data_out), 32'(v.d));
    req = 1'b0;
    tick();
    check({nm, " rel valid"}, 32'(valid), 32'd0);
    check({nm, " rel data"}, 32'(data_out), 32'd0);
    check({nm, " rel busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    vec_t v;
    vt[0]  = '{3'd2, 1'b0, 5'b00000, 5'd7,  1'b0, 1'b0, 5'd7,  1'b0};
    vt[1]  = '{3'd0, 1'b0, 5'b00000, 5'd1,  1'b1, 1'b0, 5'd31, 1'b1};
    vt[2]  = '{3'd1, 1'b0, 5'b00000, 5'd4,  1'b0, 1'b0, 5'd4,  1'b0};
    vt[3]  = '{3'd3, 1'b0, 5'b00000, 5'd0,  1'b0, 1'b0, 5'd0,  1'b0};
    vt[4]  = '{3'd4, 1'b0, 5'b00000, 5'd3,  1'b0, 1'b0, 5'd3,  1'b0};
    vt[5]  = '{3'd6, 1'b1, 5'b00000, 5'd0,  1'b0, 1'b1, 5'd0,  1'b0};
    vt[6]  = '{3'd5, 1'b0, 5'b00000, 5'd0,  1'b0, 1'b1, 5'd0,  1'b0};
    vt[7]  = '{3'd7, 1'b0, 5'b00000, 5'd0,  1'b0, 1'b1, 5'd0,  1'b0};
    vt[8]  = '{3'd2, 1'b0, 5'b00000, 5'd7,  1'b0, 1'b0, 5'd7,  1'b0};
    vt[9]  = '{3'd1, 1'b1, 5'b00010, 5'd4,  1'b0, 1'b0, 5'd4,  1'b0};
    vt[10] = '{3'd1, 1'b0, 5'b00000, 5'd1,  1'b0, 1'b0, 5'd1,  1'b0};
    vt[11] = '{3'd0, 1'b1, 5'b00000, 5'd1,  1'b1, 1'b0, 5'd31, 1'b1};
    vt[12] = '{3'd0, 1'b0, 5'b00000, 5'd0,  1'b0, 1'b0, 5'd0,  1'b0};

    reset_L = 1'b0; pop = '0; idle = 1'b0; req = 1'b0; idx = '0; clr_on_rd = 1'b0;
    tick(); tick();
    check("reset valid", 32'(valid), 32'd0);
    check("reset data", 32'(data_out), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset err", 32'(err), 32'd0);
`ifdef POP_TOTAL_EN
    check("reset total", 32'(total_out), 32'd0);
`endif
    reset_L = 1'b1;
    tick();

    // ch0 gets 33 pops, ch1 4, ch2 7, ch4 3, all counting together
    for (int k = 0; k < 33; k++) begin
      pop = {k < 3, 1'b0, k < 7, k < 4, 1'b1};
      tick();
    end
    pop = '0;

    for (int n = 0; n < 13; n++) begin
      v = vt[n];
      do_read($sformatf("vec%0d", n), v);
    end

    // idle low blocks acceptance; pops during hold do not disturb the snapshot
    idle = 1'b0; req = 1'b1; idx = 3'd2;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("noidle valid", 32'(valid), 32'd0);
      check("noidle busy", 32'(busy), 32'd0);
    end
    idle = 1'b1;
    tick();
    check("idle up valid", 32'(valid), 32'd1);
    check("idle up data", 32'(data_out), 32'd7);
    idle = 1'b0; pop = 5'b00100;
    tick(); tick();
    pop = '0;
    check("hold snapshot valid", 32'(valid), 32'd1);
    check("hold snapshot data", 32'(data_out), 32'd7);
    req = 1'b0;
    tick();
    check("snapshot rel valid", 32'(valid), 32'd0);
    v = '{3'd2, 1'b0, 5'b00000, 5'd9, 1'b0, 1'b0, 5'd9, 1'b0};
    do_read("ch2 after hold pops", v);

    // asynchronous reset while holding a read
    idle = 1'b1; req = 1'b1; idx = 3'd2;
    tick(); tick();
    check("pre-reset hold valid", 32'(valid), 32'd1);
    #2 reset_L = 1'b0;
    #1;
    check("async rst valid", 32'(valid), 32'd0);
    check("async rst data", 32'(data_out), 32'd0);
    check("async rst busy", 32'(busy), 32'd0);
    req = 1'b0;
    tick();
    reset_L = 1'b1;
    tick();
    v = '{3'd2, 1'b0, 5'b00000, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0};
    do_read("ch2 after reset", v);
    v = '{3'd1, 1'b0, 5'b00000, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0};
    do_read("ch1 after reset", v);

    pop = 5'b10101;
    for (int k = 0; k < 4; k++) tick();
    pop = '0;
`ifdef POP_TOTAL_EN
    check("total 3ch x4", 32'(total_out), 32'd12);
`endif
    v = '{3'd4, 1'b0, 5'b00000, 5'd4, 1'b0, 1'b0, 5'd4, 1'b0};
    do_read("ch4 after 4 pops", v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pop_counter_bank.md
Name: pop_counter_bank

Overview:
- Parametrised bank of per-channel pop counters; each channel's counter increments on its FIFO pop strobe.
- Counters are read one channel at a time through a registered req/valid handshake, gated by system idle.
- Adds over the previous fixed 5x5-bit counter block:
  - wrap or saturate mode;
  - sticky per-channel overflow;
  - optional clear-on-read;
  - invalid-index error;
  - async reset.
- Sits between the FIFO pop strobes and the test/status interface.

Parameters:
NUM_CH, 5, number of channels (1..2^IDX_W)
CNT_W, 5, counter width in bits
IDX_W, 3, channel index width
SATURATE, 0, 0 = counters wrap modulo 2^CNT_W; 1 = counters stick at all-ones

Ports:
clk  input  1  clock, all state updates on rising edge
reset_L  input  1  asynchronous active-low reset
pop  input  NUM_CH  per-channel pop strobe, bit i increments counter i
idle  input  1  system idle; a read is accepted only when high
req  input  1  read request, level, held until valid is seen
idx  input  IDX_W  channel to read, sampled at acceptance
clr_on_rd  input  1  clear the addressed counter and overflow flag at acceptance
valid  output  1  read data valid
data_out  output  CNT_W  counter value of the accepted read
ovf  output  1  sticky overflow flag of the channel read
err  output  1  accepted idx was >= NUM_CH
busy  output  1  FSM not in S_WAIT

Behaviour:
- Reset (reset_L low, asynchronous, any state):
  - all counters, overflow flags, valid, data_out, ovf, err and busy are 0;
  - FSM goes to S_WAIT.
  - Reset deassertion is sampled at the next clk edge.
- Counting, per channel i, each clk edge with pop[i]=1:
  - Wrap mode: cnt <= cnt+1 mod 2^CNT_W. Ovf flag i is set when cnt is all-ones.
  - Saturate mode: cnt holds at all-ones. Ovf flag i is set on the first pop at all-ones.
  - The ovf flag stays set until reset or a clear-on-read of that channel.
  - All channels count independently in the same cycle.
- FSM states: S_WAIT, S_DATA, S_HOLD.
  - S_WAIT:
    - Acceptance = req & idle.
    - On acceptance: capture data_out = counter[idx] and ovf = flag[idx], using register values before any same-cycle pop.
    - err = (idx >= NUM_CH). When err=1, data_out=0 and ovf=0.
    - Go to S_DATA.
  - S_DATA: valid=1 (first cycle after acceptance, so latency is exactly 1 cycle). Go to S_HOLD if req=1, else S_WAIT.
  - S_HOLD:
    - valid, data_out, ovf and err are held stable while req=1; idle is ignored.
    - When req=0, go to S_WAIT.
  - Outputs in and after the transition to S_WAIT: valid=0, data_out=0, ovf=0, err=0.
  - busy=1 in S_DATA and S_HOLD.
- A new read needs req low for at least one cycle (return to S_WAIT), then a fresh acceptance.
- req high while idle low: no acceptance, valid stays 0, FSM stays in S_WAIT.
- Clear-on-read (clr_on_rd=1 at acceptance with a valid idx):
  - counter[idx] and flag[idx] are cleared at the acceptance edge;
  - a same-cycle pop[idx] is not lost, so the counter becomes 1;
  - data_out still reports the pre-clear value.
  - clr_on_rd with an invalid idx has no effect.
- Pops continue during S_DATA/S_HOLD. The held data_out is a snapshot and does not track them.
- Reset mid-read: valid drops immediately (asynchronously); the read is abandoned.

Optional Feature:
- Macro: POP_TOTAL_EN.
- When defined:
  - adds output port total_out, width CNT_W+IDX_W, counting every pop on all channels;
  - total_out increments by the popcount of pop each cycle and always wraps;
  - cleared only by reset, never by clear-on-read.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then pop[2] pulsed 7 cycles, idle=1, req=1, idx=2 -> valid=1 one cycle after acceptance, data_out=7, ovf=0, err=0; values held while req high; valid=0 after req drops.
- CNT_W=5, SATURATE=0, 33 pops on channel 0, read idx=0 -> data_out=1, ovf=1. With SATURATE=1 -> data_out=31, ovf=1.
- Counter 1 at 4, req with clr_on_rd=1 and pop[1]=1 in the acceptance cycle -> data_out=4; a second read returns 1, ovf=0.
- idle=0 with req=1 for 5 cycles -> valid stays 0 and busy=0. Raise idle -> valid on the following cycle.
- idx=6 with NUM_CH=5 -> valid=1, err=1, data_out=0; counters unaffected.
- reset_L asserted low while in S_HOLD with valid=1 -> valid, data_out and all counters are 0 before the next clk edge. With POP_TOTAL_EN defined, pops on 3 channels for 4 cycles give total_out=12.
